// File: rtl/zion_rr_dff_arbiter_pkg.sv
// rtl/zion_rr_dff_arbiter_pkg.sv - shared types and round-robin search for the arbiter
package zion_rr_dff_arbiter_pkg;

    localparam int MAX_REQ   = 16;
    localparam int MAX_IDX_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } ArbState_t;

    typedef struct packed {
        logic                 found;
        logic [MAX_IDX_W-1:0] idx;
    } RrPick_t;

    // First valid requester at or above ptr, wrapping at numReq (ptr < numReq assumed)
    function automatic RrPick_t RrPick(
        input logic [MAX_REQ-1:0]   vld,
        input logic [MAX_IDX_W-1:0] ptr,
        input int unsigned          numReq
    );
        RrPick_t     res;
        int unsigned idx;
        res = '0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= numReq) begin
                idx = idx - numReq;
            end
            if (k < numReq && !res.found && vld[idx[MAX_IDX_W-1:0]]) begin
                res.found = 1'b1;
                res.idx   = idx[MAX_IDX_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/zion_clr_en_dff.sv
// rtl/zion_clr_en_dff.sv - clear/enable holding register with selectable reset style
module zion_clr_en_dff #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] INI_DATA = '0,
    parameter int               RST_CFG  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iEn,
    input  logic             iClr,
    input  logic [WIDTH-1:0] iDat,
    output logic [WIDTH-1:0] oDat
);

    logic [WIDTH-1:0] q;

    generate
        if (RST_CFG == 3) begin : gSyncHigh
            // Synchronous active-high reset; clear beats enable
            always_ff @(posedge clk) begin
                if (rst) begin
                    q <= INI_DATA;
                end else if (iClr) begin
                    q <= INI_DATA;
                end else if (iEn) begin
                    q <= iDat;
                end
            end
        end else if (RST_CFG == 2) begin : gSyncLow
            // Synchronous active-low reset; clear beats enable
            always_ff @(posedge clk) begin
                if (!rst) begin
                    q <= INI_DATA;
                end else if (iClr) begin
                    q <= INI_DATA;
                end else if (iEn) begin
                    q <= iDat;
                end
            end
        end else begin : gNoRst
            // No reset; clear beats enable
            always_ff @(posedge clk) begin
                if (iClr) begin
                    q <= INI_DATA;
                end else if (iEn) begin
                    q <= iDat;
                end
            end
        end
    endgenerate

    assign oDat = q;

endmodule

// File: rtl/zion_rr_picker.sv
// rtl/zion_rr_picker.sv - combinational round-robin priority search
module zion_rr_picker
    import zion_rr_dff_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] iVld,
    input  logic [IDX_W-1:0]   iPtr,
    output logic               oFound,
    output logic [IDX_W-1:0]   oIdx
);

    RrPick_t pick;

    // Widen to the package's maximum size and run the shared search
    always_comb begin
        pick   = RrPick(MAX_REQ'(iVld), MAX_IDX_W'(iPtr), NUM_REQ);
        oFound = pick.found;
        oIdx   = pick.idx[IDX_W-1:0];
    end

endmodule

// File: rtl/zion_rr_dff_arbiter.sv
// rtl/zion_rr_dff_arbiter.sv - round-robin arbiter with burst lock driving a shared clear/enable register
module zion_rr_dff_arbiter
    import zion_rr_dff_arbiter_pkg::*;
#(
    parameter int               NUM_REQ  = 4,
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] INI_DATA = '0,
    parameter int               LOCK_TMO = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              iReqVld,
    input  logic [NUM_REQ-1:0]              iReqClr,
    input  logic [NUM_REQ-1:0]              iReqLast,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]   iReqDat,
    output logic [NUM_REQ-1:0]              oReqRdy,
    output logic [WIDTH-1:0]                oDat,
    output logic [$clog2(NUM_REQ)-1:0]      oOwner,
    output logic                            oBusy,
    output logic                            oUpdVld
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = (LOCK_TMO > 0) ? $clog2(LOCK_TMO + 1) : 1;
    localparam bit TMO_EN = (LOCK_TMO > 0);
    localparam logic [CNT_W-1:0] TMO_LAST = (LOCK_TMO > 0) ? CNT_W'(LOCK_TMO - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = (LOCK_TMO > 0) ? CNT_W'(LOCK_TMO) : '1;
    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(NUM_REQ - 1);

    ArbState_t        state, stateNxt;
    logic [IDX_W-1:0] ptr, ptrNxt;
    logic [IDX_W-1:0] owner, ownerNxt;
    logic [CNT_W-1:0] cnt, cntNxt;
    logic             updVld;
    logic             pickFound;
    logic [IDX_W-1:0] pickIdx;
    logic [IDX_W-1:0] win;
    logic             hs;

    // Explicit wrap so non-power-of-2 requester counts never reach NUM_REQ
    function automatic logic [IDX_W-1:0] wrapInc(input logic [IDX_W-1:0] i);
        return (i == IDX_TOP) ? '0 : i + 1'b1;
    endfunction

    zion_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) uPicker (
        .iVld   (iReqVld),
        .iPtr   (ptr),
        .oFound (pickFound),
        .oIdx   (pickIdx)
    );

    // Grant selection, lock/unlock decisions and timeout counting
    always_comb begin
        stateNxt = state;
        ptrNxt   = ptr;
        ownerNxt = owner;
        cntNxt   = cnt;
        oReqRdy  = '0;
        hs       = 1'b0;
        win      = pickIdx;
        case (state)
            IDLE: begin
                win = pickIdx;
                if (pickFound) begin
                    oReqRdy[pickIdx] = 1'b1;
                    hs               = 1'b1;
                    ownerNxt         = pickIdx;
                    if (iReqLast[pickIdx]) begin
                        ptrNxt = wrapInc(pickIdx);
                    end else begin
                        stateNxt = LOCK;
                        cntNxt   = '0;
                    end
                end
            end
            LOCK: begin
                win = owner;
                if (iReqVld[owner]) begin
                    oReqRdy[owner] = 1'b1;
                    hs             = 1'b1;
                    cntNxt         = '0;
                    if (iReqLast[owner]) begin
                        stateNxt = IDLE;
                        ptrNxt   = wrapInc(owner);
                    end
                end else if (TMO_EN && cnt == TMO_LAST) begin
                    stateNxt = IDLE;
                    ptrNxt   = wrapInc(owner);
                end else if (cnt != CNT_MAX) begin
                    cntNxt = cnt + 1'b1;
                end
            end
            default: begin
                stateNxt = IDLE;
            end
        endcase
    end

    // Control state registers; reset overrides any burst in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= '0;
            owner  <= '0;
            cnt    <= '0;
            updVld <= 1'b0;
        end else begin
            state  <= stateNxt;
            ptr    <= ptrNxt;
            owner  <= ownerNxt;
            cnt    <= cntNxt;
            updVld <= hs;
        end
    end

    zion_clr_en_dff #(
        .WIDTH    (WIDTH),
        .INI_DATA (INI_DATA),
        .RST_CFG  (3)
    ) uReg (
        .clk  (clk),
        .rst  (rst),
        .iEn  (hs),
        .iClr (hs && iReqClr[win]),
        .iDat (iReqDat[win]),
        .oDat (oDat)
    );

    assign oOwner  = owner;
    assign oBusy   = (state == LOCK);
    assign oUpdVld = updVld;

endmodule
